// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_t;

  localparam int DMEM_WS_W = 4;

  function automatic int dmem_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dmem_storage.sv
// Byte storage split into one array per lane; synchronous per-lane write, asynchronous read.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 256
) (
  input  logic                                                 clk,
  input  logic [$clog2(DEPTH_BYTES/(DATA_WIDTH/8))-1:0]        row,
  input  logic [DATA_WIDTH/8-1:0]                              we,
  input  logic [DATA_WIDTH-1:0]                                wdata,
  output logic [DATA_WIDTH-1:0]                                rdata
);

  localparam int B    = dmem_lanes(DATA_WIDTH);
  localparam int ROWS = DEPTH_BYTES / B;

  // Lane i holds data bits [8i+7:8i]; big-endian placement is implied by the lane order.
  for (genvar i = 0; i < B; i++) begin : g_lane
    logic [7:0] lane_mem [ROWS];

    always_ff @(posedge clk) begin
      if (we[i]) lane_mem[row] <= wdata[8*i +: 8];
    end

    assign rdata[8*i +: 8] = lane_mem[row];
  end

endmodule

// File: rtl/wait_state_data_memory.sv
// Byte-addressed big-endian data memory with programmable wait states and a ready/error pulse.
// Optional macro DMEM_ALIGN_CHECK_EN turns unaligned addresses into faults.
module wait_state_data_memory
  import dmem_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MEM_r_en,
  input  logic                      MEM_w_en,
  input  logic [31:0]               address,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      ready,
  output logic                      error
);

  localparam int B  = dmem_lanes(DATA_WIDTH);
  localparam int LB = $clog2(B);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [DMEM_WS_W-1:0] WS       = DMEM_WS_W'(WAIT_STATES);
  localparam logic [31:0]          DEPTH32  = 32'(DEPTH_BYTES);
  localparam logic [31:0]          LOW_MASK = 32'(B - 1);

  dmem_state_t           state;
  logic [DMEM_WS_W-1:0]  count;
  logic                  cap_r, cap_w;
  logic [31:0]           cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [B-1:0]          cap_ben;

  logic                  in_idle, req, finish, fault;
  logic                  cur_r, cur_w;
  logic [31:0]           cur_addr, offset;
  logic [DATA_WIDTH-1:0] cur_data, rdata;
  logic [B-1:0]          cur_ben, lane_we;

  // With zero wait states the access completes on the capturing edge, so the live inputs are used there.
  always_comb begin
    in_idle  = (state == IDLE);
    req      = MEM_r_en | MEM_w_en;
    cur_r    = in_idle ? MEM_r_en : cap_r;
    cur_w    = in_idle ? MEM_w_en : cap_w;
    cur_addr = in_idle ? address  : cap_addr;
    cur_data = in_idle ? data_in  : cap_data;
    cur_ben  = in_idle ? byte_en  : cap_ben;
    finish   = rst && (in_idle ? (req && (WS == '0))
                               : ((state == WAIT) && (count == DMEM_WS_W'(1))));
    offset   = cur_addr - BASE_ADDR;
    fault    = (cur_addr < BASE_ADDR) || (offset >= DEPTH32) || (cur_r && cur_w);
`ifdef DMEM_ALIGN_CHECK_EN
    fault    = fault || ((cur_addr & LOW_MASK) != '0);
`endif
    lane_we  = (finish && cur_w && !fault) ? cur_ben : '0;
  end

  dmem_storage #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_storage (
    .clk   (clk),
    .row   (offset[AW-1:LB]),
    .we    (lane_we),
    .wdata (cur_data),
    .rdata (rdata)
  );

  // ready/error are registered on the completing edge, so they are high during the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      ready    <= 1'b0;
      error    <= 1'b0;
      data_out <= '0;
      cap_r    <= 1'b0;
      cap_w    <= 1'b0;
      cap_addr <= '0;
      cap_data <= '0;
      cap_ben  <= '0;
    end else begin
      ready <= finish;
      error <= finish && fault;
      if (finish && (fault || cur_r)) data_out <= fault ? '0 : rdata;
      case (state)
        IDLE: begin
          if (req) begin
            cap_r    <= MEM_r_en;
            cap_w    <= MEM_w_en;
            cap_addr <= address;
            cap_data <= data_in;
            cap_ben  <= byte_en;
            count    <= WS;
            state    <= (WS == '0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          count <= count - DMEM_WS_W'(1);
          if (count == DMEM_WS_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Bench: instance 0 runs with no wait states, instance 1 with two; a byte-array model checks every cycle.
module tb_wait_state_data_memory;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  r_en = '0;
  logic [1:0]  w_en = '0;
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [3:0]  ben  [2];
  logic [31:0] dout [2];
  logic [1:0]  rdy;
  logic [1:0]  err;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          valid;
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    int          done;
  } op_t;

  op_t         pend [2];
  logic [7:0]  mem_m [2][256];
  logic [31:0] exp_dout [2];

  wait_state_data_memory #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MEM_r_en(r_en[0]), .MEM_w_en(w_en[0]), .address(addr[0]),
    .data_in(din[0]), .byte_en(ben[0]), .data_out(dout[0]), .ready(rdy[0]), .error(err[0])
  );

  wait_state_data_memory #(.WAIT_STATES(2)) u_dut1 (
    .clk(clk), .rst(rst), .MEM_r_en(r_en[1]), .MEM_w_en(w_en[1]), .address(addr[1]),
    .data_in(din[1]), .byte_en(ben[1]), .data_out(dout[1]), .ready(rdy[1]), .error(err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_fault(input bit r, input bit w, input logic [31:0] a);
    bit f;
    f = (a < BASE) || (a >= BASE + 32'd256) || (r && w);
`ifdef DMEM_ALIGN_CHECK_EN
    f = f || (a[1:0] != 2'b00);
`endif
    return f;
  endfunction

  function automatic logic [31:0] model_word(input int k, input logic [31:0] a);
    int o;
    o = int'((a - BASE) & ~32'd3);
    return {mem_m[k][o], mem_m[k][o+1], mem_m[k][o+2], mem_m[k][o+3]};
  endfunction

  function automatic logic [7:0] model_byte(input int k, input logic [31:0] a);
    return mem_m[k][int'(a - BASE)];
  endfunction

  // Model: an accepted access completes WAIT_STATES+1 cycles after capture; reset drops it.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit er, ee;
      er = 1'b0;
      ee = 1'b0;
      if (!rst) begin
        pend[k].valid = 1'b0;
        exp_dout[k]   = '0;
      end else if (pend[k].valid && cyc == pend[k].done) begin
        er = 1'b1;
        ee = is_fault(pend[k].r, pend[k].w, pend[k].a);
        if (!ee && pend[k].w) begin
          for (int i = 0; i < 4; i++)
            if (pend[k].be[i])
              mem_m[k][int'((pend[k].a - BASE) & ~32'd3) + 3 - i] = pend[k].d[8*i +: 8];
        end
        if (ee) exp_dout[k] = '0;
        else if (pend[k].r) exp_dout[k] = model_word(k, pend[k].a);
        pend[k].valid = 1'b0;
      end
      check_output($sformatf("ready%0d", k), 32'(rdy[k]), 32'(er));
      check_output($sformatf("error%0d", k), 32'(err[k]), 32'(ee));
      check_output($sformatf("data_out%0d", k), dout[k], exp_dout[k]);
    end
  end

  // Called at posedge+1; holds enables through the ready cycle and drops them in the next one.
  task automatic apply_stimulus(input int k, input bit r, input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] be,
                                output logic got_rdy, output logic got_err);
    int done;
    done = cyc + 1 + ((k == 0) ? 0 : 2);
    got_rdy = 1'b0;
    got_err = 1'b0;
    r_en[k] = r;
    w_en[k] = w;
    addr[k] = a;
    din[k]  = d;
    ben[k]  = be;
    pend[k].valid = 1'b1;
    pend[k].r     = r;
    pend[k].w     = w;
    pend[k].a     = a;
    pend[k].d     = d;
    pend[k].be    = be;
    pend[k].done  = done;
    while (cyc <= done) begin
      if (cyc == done) begin
        @(negedge clk);
        got_rdy = rdy[k];
        got_err = err[k];
      end
      @(posedge clk);
      #1;
    end
    r_en[k] = 1'b0;
    w_en[k] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic gr, ge;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; din[k] = '0; ben[k] = '0;
      pend[k].valid = 1'b0;
      exp_dout[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Full-word write then read, 3 cycles to ready
    apply_stimulus(1, 0, 1, 32'd1028, 32'h11223344, 4'hF, gr, ge);
    check_output("wr1028_ready", 32'(gr), 32'd1);
    apply_stimulus(1, 1, 0, 32'd1028, 32'h0, 4'h0, gr, ge);
    check_output("rd1028_ready", 32'(gr), 32'd1);
    check_output("rd1028_data", dout[1], 32'h11223344);
    check_output("model_byte1028", 32'(model_byte(1, 32'd1028)), 32'h11);

    // Partial lane write
    apply_stimulus(1, 0, 1, 32'd1028, 32'hAABBCCDD, 4'b0101, gr, ge);
    apply_stimulus(1, 1, 0, 32'd1028, 32'h0, 4'h0, gr, ge);
    check_output("rd_partial", dout[1], 32'h11BB33DD);

    // Out-of-range reads
    apply_stimulus(1, 1, 0, 32'd1020, 32'h0, 4'h0, gr, ge);
    check_output("rd1020_err", 32'({gr, ge}), 32'b11);
    check_output("rd1020_data", dout[1], 32'h0);
    apply_stimulus(1, 1, 0, 32'd1280, 32'h0, 4'h0, gr, ge);
    check_output("rd1280_err", 32'({gr, ge}), 32'b11);
    apply_stimulus(1, 1, 0, 32'd1028, 32'h0, 4'h0, gr, ge);
    check_output("rd1028_after_err", dout[1], 32'h11BB33DD);

    // Reset in WAIT aborts a write
    apply_stimulus(1, 0, 1, 32'd1036, 32'h55667788, 4'hF, gr, ge);
    r_en[1] = 1'b0; w_en[1] = 1'b1; addr[1] = 32'd1036; din[1] = 32'hDEADBEEF; ben[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    w_en[1] = 1'b0;
    @(negedge clk);
    check_output("rst_ready", 32'(rdy[1]), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(1, 1, 0, 32'd1036, 32'h0, 4'h0, gr, ge);
    check_output("rd1036_after_abort", dout[1], 32'h55667788);

    // Unaligned read
    apply_stimulus(1, 1, 0, 32'd1030, 32'h0, 4'h0, gr, ge);
`ifdef DMEM_ALIGN_CHECK_EN
    check_output("rd1030_err", 32'({gr, ge}), 32'b11);
    check_output("rd1030_data", dout[1], 32'h0);
`else
    check_output("rd1030_err", 32'({gr, ge}), 32'b10);
    check_output("rd1030_data", dout[1], 32'h11BB33DD);
`endif

    // Zero wait states: back-to-back writes, ready every 2nd cycle
    apply_stimulus(0, 0, 1, 32'd1024, 32'hCAFEF00D, 4'hF, gr, ge);
    check_output("ws0_wr1024_ready", 32'(gr), 32'd1);
    apply_stimulus(0, 0, 1, 32'd1032, 32'h0BADBEEF, 4'hF, gr, ge);
    check_output("ws0_wr1032_ready", 32'(gr), 32'd1);
    apply_stimulus(0, 1, 0, 32'd1024, 32'h0, 4'h0, gr, ge);
    check_output("ws0_rd1024", dout[0], 32'hCAFEF00D);
    apply_stimulus(0, 1, 0, 32'd1032, 32'h0, 4'h0, gr, ge);
    check_output("ws0_rd1032", dout[0], 32'h0BADBEEF);

    // Both enables high is a fault with no write; byte_en 0 writes nothing
    apply_stimulus(0, 1, 1, 32'd1024, 32'h12345678, 4'hF, gr, ge);
    check_output("ws0_rw_err", 32'({gr, ge}), 32'b11);
    apply_stimulus(0, 0, 1, 32'd1032, 32'h99999999, 4'h0, gr, ge);
    check_output("ws0_be0_err", 32'({gr, ge}), 32'b10);
    apply_stimulus(0, 1, 0, 32'd1024, 32'h0, 4'h0, gr, ge);
    check_output("ws0_rd1024_kept", dout[0], 32'hCAFEF00D);
    apply_stimulus(0, 1, 0, 32'd1032, 32'h0, 4'h0, gr, ge);
    check_output("ws0_rd1032_kept", dout[0], 32'h0BADBEEF);

    repeat (3) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
